// File: rtl/mask_writer_pkg.sv
// Shared types and frame geometry for the mask writer/reader pair.
package mask_writer_pkg;

  localparam int MASK_WORD_W    = 16;
  localparam int MASK_ADDR_W    = 15;
  localparam int FRAME_H_ACTIVE = 640;
  localparam int FRAME_V_ACTIVE = 480;
  localparam int FRAME_WORDS    = FRAME_H_ACTIVE * FRAME_V_ACTIVE / MASK_WORD_W;

  localparam logic [MASK_WORD_W-1:0] MASK_WORD_ONES = {MASK_WORD_W{1'b1}};

  typedef struct packed {
    logic [MASK_ADDR_W-1:0] addr;
    logic [MASK_WORD_W-1:0] data;
  } mask_entry_t;

  localparam mask_entry_t ENTRY_RESET = {{MASK_ADDR_W{1'b0}}, {MASK_WORD_W{1'b1}}};

  typedef enum logic [1:0] {
    PK_EMPTY   = 2'd0,
    PK_ACCUM   = 2'd1,
    PK_PENDING = 2'd2
  } pack_state_e;

  function automatic logic [MASK_WORD_W-1:0] set_mask_bit(
    input logic [MASK_WORD_W-1:0] word,
    input logic [3:0]             pos,
    input logic                   bit_val
  );
    logic [MASK_WORD_W-1:0] res;
    res      = word;
    res[pos] = bit_val;
    return res;
  endfunction

endpackage

// File: rtl/mask_word_fifo.sv
// Word queue between the packer and the memory write port; a push into a
// full queue is accepted only when the head is popped on the same edge.
module mask_word_fifo
  import mask_writer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  mask_entry_t push_entry_i,
  input  logic        pop_i,
  output mask_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  mask_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty_o   = (count_q == {(PTR_W+1){1'b0}});
  assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);
  assign head_o    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_d = count_q - (PTR_W+1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= ENTRY_RESET;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mask_writer.sv
// Packs the per-pixel mask stream into 16-bit words and writes them to the
// frame mask memory through a queued req/ack port.
module mask_writer
  import mask_writer_pkg::*;
#(
  parameter int H_ACTIVE   = FRAME_H_ACTIVE,
  parameter int V_ACTIVE   = FRAME_V_ACTIVE,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                   clk_25,
  input  logic                   rst_n,
  input  logic                   valid,
  input  logic                   mask,
  input  logic [9:0]             mask_x,
  input  logic [9:0]             mask_y,
  output logic                   wr_req,
  output logic [MASK_ADDR_W-1:0] wr_addr,
  output logic [MASK_WORD_W-1:0] wr_data,
  input  logic                   wr_ack,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam int WORDS_PER_LINE = H_ACTIVE / MASK_WORD_W;
  localparam logic [MASK_ADDR_W-1:0] LAST_ADDR =
    MASK_ADDR_W'(BASE_ADDR + H_ACTIVE * V_ACTIVE / MASK_WORD_W - 1);

  pack_state_e            state_q, state_d;
  logic [MASK_ADDR_W-1:0] acc_addr_q, acc_addr_d;
  logic [MASK_WORD_W-1:0] acc_data_q, acc_data_d;
  logic                   overflow_q;
  logic                   frame_done_q;

  logic [MASK_ADDR_W-1:0] pix_addr_s;
  logic [MASK_WORD_W-1:0] new_data_s;
  logic [MASK_WORD_W-1:0] merged_s;
  logic                   frame_start_s;
  logic                   word_last_s;
  logic                   same_word_s;
  logic                   push_s;
  mask_entry_t            push_entry_s;
  logic                   pop_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  mask_entry_t            head_s;

  // Line width is a multiple of 16, so the word index never straddles rows.
  assign pix_addr_s    = MASK_ADDR_W'(mask_y) * MASK_ADDR_W'(WORDS_PER_LINE)
                       + MASK_ADDR_W'(mask_x[9:4]) + MASK_ADDR_W'(BASE_ADDR);
  assign frame_start_s = valid && (mask_x == 10'd0) && (mask_y == 10'd0);
  assign word_last_s   = (mask_x[3:0] == 4'd15);
  assign same_word_s   = (pix_addr_s == acc_addr_q) && !frame_start_s;
  assign new_data_s    = set_mask_bit(MASK_WORD_ONES, mask_x[3:0], mask);
  assign merged_s      = set_mask_bit(acc_data_q, mask_x[3:0], mask);
  assign pop_s         = wr_ack && !fifo_empty_s;

  always_comb begin
    state_d      = state_q;
    acc_addr_d   = acc_addr_q;
    acc_data_d   = acc_data_q;
    push_s       = 1'b0;
    push_entry_s = {acc_addr_q, acc_data_q};
    case (state_q)
      PK_EMPTY: begin
        if (valid && word_last_s) begin
          push_s       = 1'b1;
          push_entry_s = {pix_addr_s, new_data_s};
        end else if (valid) begin
          state_d    = PK_ACCUM;
          acc_addr_d = pix_addr_s;
          acc_data_d = new_data_s;
        end else begin
          state_d = PK_EMPTY;
        end
      end
      PK_ACCUM: begin
        if (valid && same_word_s && word_last_s) begin
          push_s       = 1'b1;
          push_entry_s = {acc_addr_q, merged_s};
          state_d      = PK_EMPTY;
          acc_data_d   = MASK_WORD_ONES;
        end else if (valid && same_word_s) begin
          acc_data_d = merged_s;
        end else if (valid) begin
          // Flush the partial word; a completing newcomer waits one edge.
          push_s     = 1'b1;
          acc_addr_d = pix_addr_s;
          acc_data_d = new_data_s;
          state_d    = word_last_s ? PK_PENDING : PK_ACCUM;
        end else begin
          state_d = PK_ACCUM;
        end
      end
      PK_PENDING: begin
        push_s = 1'b1;
        if (valid) begin
          acc_addr_d = pix_addr_s;
          acc_data_d = new_data_s;
          state_d    = word_last_s ? PK_PENDING : PK_ACCUM;
        end else begin
          acc_data_d = MASK_WORD_ONES;
          state_d    = PK_EMPTY;
        end
      end
      default: begin
        state_d    = PK_EMPTY;
        acc_data_d = MASK_WORD_ONES;
      end
    endcase
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PK_EMPTY;
      acc_addr_q   <= {MASK_ADDR_W{1'b0}};
      acc_data_q   <= MASK_WORD_ONES;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_addr_q   <= acc_addr_d;
      acc_data_q   <= acc_data_d;
      frame_done_q <= pop_s && (head_s.addr == LAST_ADDR);
      // A drop on the frame-start edge still counts as an overflow.
      if (push_s && fifo_full_s && !pop_s) begin
        overflow_q <= 1'b1;
      end else if (frame_start_s) begin
        overflow_q <= 1'b0;
      end else begin
        overflow_q <= overflow_q;
      end
    end
  end

  mask_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk_25),
    .rst_ni       (rst_n),
    .push_i       (push_s),
    .push_entry_i (push_entry_s),
    .pop_i        (wr_ack),
    .head_o       (head_s),
    .full_o       (fifo_full_s),
    .empty_o      (fifo_empty_s)
  );

  assign wr_req     = !fifo_empty_s;
  assign wr_addr    = head_s.addr;
  assign wr_data    = head_s.data;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_mask_writer.sv
// Randomised bench for mask_writer against a word-level packing/queue model.
module tb_mask_writer;

  localparam int H     = 160;
  localparam int V     = 24;
  localparam int DEPTH = 4;
  localparam int BASE  = 0;
  localparam int NWORD = H * V / 16;
  localparam int LAST  = BASE + NWORD - 1;

  logic        clk_25 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        valid  = 1'b0;
  logic        mask   = 1'b0;
  logic [9:0]  mask_x = 10'd0;
  logic [9:0]  mask_y = 10'd0;
  logic        wr_ack = 1'b0;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;
  logic        frame_done;
  logic        overflow;

  mask_writer #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .FIFO_DEPTH (DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk_25     (clk_25),
    .rst_n      (rst_n),
    .valid      (valid),
    .mask       (mask),
    .mask_x     (mask_x),
    .mask_y     (mask_y),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #20 clk_25 = ~clk_25;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: accumulator, carried (deferred) word, write queue, flags.
  logic [30:0] fq[$];
  logic [30:0] carry;
  bit          carry_v;
  bit          acc_open;
  int          acc_addr;
  logic [15:0] acc_data;
  bit          ovf_m;
  bit          done_m;

  logic [30:0] obs[$];
  int          req_cycles;
  int          done_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int word_addr(input int x, input int y);
    return (((y * H + x) >> 4) + BASE) % 32768;
  endfunction

  task automatic model_reset();
    fq.delete();
    carry_v  = 1'b0;
    acc_open = 1'b0;
    acc_data = 16'hFFFF;
    ovf_m    = 1'b0;
    done_m   = 1'b0;
  endtask

  task automatic model_edge(input bit v, input bit m, input int x, input int y, input bit a);
    logic [30:0] outl[$];
    logic [30:0] popped;
    bit          pop;
    bit          full_pre;
    int          idx;
    full_pre = (fq.size() == DEPTH);
    pop      = a && (fq.size() > 0);
    popped   = 31'd0;
    if (pop) popped = fq.pop_front();
    done_m = pop && (popped[30:16] == 15'(LAST));
    if (carry_v) outl.push_back(carry);
    carry_v = 1'b0;
    if (v) begin
      idx = word_addr(x, y);
      if (x == 0 && y == 0) ovf_m = 1'b0;
      if (acc_open && (idx != acc_addr || (x == 0 && y == 0))) begin
        outl.push_back({15'(acc_addr), acc_data});
        acc_open = 1'b0;
      end
      if (!acc_open) begin
        acc_open = 1'b1;
        acc_addr = idx;
        acc_data = 16'hFFFF;
      end
      acc_data[x % 16] = m;
      if (x % 16 == 15) begin
        outl.push_back({15'(acc_addr), acc_data});
        acc_open = 1'b0;
      end
    end
    // Only one word enters the queue per edge; a second is deferred.
    if (outl.size() > 1) begin
      carry   = outl[1];
      carry_v = 1'b1;
    end
    if (outl.size() > 0) begin
      if (!full_pre || pop) fq.push_back(outl[0]);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic tick(input bit v, input bit m, input int x, input int y, input bit a);
    @(negedge clk_25);
    check("wr_req", wr_req, fq.size() > 0);
    if (fq.size() > 0) begin
      check("wr_addr", wr_addr, fq[0][30:16]);
      check("wr_data", wr_data, fq[0][15:0]);
    end
    check("overflow", overflow, ovf_m);
    check("frame_done", frame_done, done_m);
    if (wr_req) req_cycles++;
    if (frame_done) done_cnt++;
    valid  = v;
    mask   = m;
    mask_x = 10'(x);
    mask_y = 10'(y);
    wr_ack = a;
    if (wr_req && a) obs.push_back({wr_addr, wr_data});
    model_edge(v, m, x, y, a);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, wr_req, 1'b0);
    check({tag, "_addr"}, wr_addr, 15'd0);
    check({tag, "_data"}, wr_data, 16'hFFFF);
    check({tag, "_done"}, frame_done, 1'b0);
    check({tag, "_ovf"}, overflow, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_25);
    rst_n  = 1'b0;
    valid  = 1'b0;
    wr_ack = 1'b0;
    model_reset();
    @(negedge clk_25);
    check_reset_vals("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x;
    int y;
    int bad;
    int ack_pct;
    model_reset();
    do_reset();

    // Single complete word with one cleared bit.
    obs.delete();
    req_cycles = 0;
    for (int i = 0; i < 16; i++) tick(1'b1, i != 5, i, 0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 0, 0, 1'b1);
    check("t1_count", obs.size(), 1);
    if (obs.size() > 0) check("t1_word", obs[0], {15'd0, 16'hFFDF});
    check("t1_req_cycles", req_cycles, 1);

    // Skipped pixels flush a partial word.
    obs.delete();
    for (int i = 16; i < 20; i++) tick(1'b1, 1'b0, i, 0, 1'b1);
    tick(1'b1, 1'b1, 48, 0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 0, 0, 1'b1);
    check("t2_count", obs.size(), 1);
    if (obs.size() > 0) check("t2_word", obs[0], {15'd1, 16'hFFF0});

    // Completing pixel on an index change becomes a deferred word.
    obs.delete();
    tick(1'b1, 1'b0, 31, 0, 1'b1);
    tick(1'b1, 1'b0, 40, 0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 0, 0, 1'b1);
    check("t3_count", obs.size(), 2);
    if (obs.size() > 1) begin
      check("t3_flush", obs[0], {15'd3, 16'hFFFF});
      check("t3_pending", obs[1], {15'd1, 16'h7FFF});
    end

    // Overflow with the port stalled.
    do_reset();
    obs.delete();
    for (int i = 0; i < 80; i++) tick(1'b1, 1'($urandom % 2), i, 1, 1'b0);
    tick(1'b0, 1'b0, 0, 0, 1'b0);
    check("t4_ovf_set", overflow, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 0, 0, 1'b1);
    check("t4_writes", obs.size(), 4);
    tick(1'b1, 1'b1, 0, 0, 1'b1);
    tick(1'b0, 1'b0, 0, 0, 1'b1);
    check("t4_ovf_clear", overflow, 1'b0);

    // Asynchronous reset with words queued.
    do_reset();
    obs.delete();
    for (int i = 0; i < 48; i++) tick(1'b1, 1'($urandom % 2), i, 2, 1'b0);
    tick(1'b0, 1'b0, 0, 0, 1'b0);
    check("t5_req_before", wr_req, 1'b1);
    #5;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t5_async");
    model_reset();
    obs.delete();
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 0, 0, 1'b1);
    check("t5_no_write", obs.size(), 0);

    // Randomised stream with jumps, gaps, frame starts and varying ack rate.
    do_reset();
    x = 0;
    y = 0;
    ack_pct = 50;
    for (int i = 0; i < 2500; i++) begin
      int r;
      bit v;
      if (i % 400 == 0) ack_pct = $urandom_range(5, 95);
      r = $urandom % 100;
      if (r < 2) begin
        x = 0;
        y = 0;
      end else if (r < 6) begin
        x = $urandom % H;
        y = $urandom % V;
      end
      v = ($urandom % 4) != 0;
      tick(v, 1'($urandom % 2), x, y, ($urandom % 100) < ack_pct);
      if (v) begin
        x++;
        if (x == H) begin
          x = 0;
          y = (y + 1) % V;
        end
      end
    end

    // Full frame, raster order, ack 50%.
    do_reset();
    obs.delete();
    done_cnt = 0;
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++)
        tick(1'b1, 1'($urandom % 2), xx, yy, 1'($urandom % 2));
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 0, 0, 1'b1);
    check("frame_writes", obs.size(), NWORD);
    bad = 0;
    foreach (obs[k]) if (obs[k][30:16] != 15'(BASE + k)) bad++;
    check("frame_order", bad, 0);
    check("frame_done_count", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mask_writer.md
# mask_writer

Consumer end of the mask stream. Accepts one mask bit per cycle with its pixel coordinate and packs the bits into 16-bit words, one word per 16 horizontally adjacent pixels. Completed words are queued in a small FIFO and written to the frame mask memory through a req/ack write port. Sits between the mask generator and the memory arbiter, all on the 25 MHz pixel clock.

## Interface
- H_ACTIVE, 640: pixels per line. Must be a multiple of 16.
- V_ACTIVE, 480: lines per frame.
- FIFO_DEPTH, 4: number of word entries in the write queue. Power of two, ≥2.
- BASE_ADDR, 0: word address of pixel (0,0).
- clk_25  in  1  sole clock.
- rst_n  in  1  reset, asynchronous, active-low.
- valid  in  1  mask/mask_x/mask_y are sampled on this edge.
- mask  in  1  mask bit. 1 = keep, 0 = differs.
- mask_x  in  10  pixel column.
- mask_y  in  10  pixel row.
- wr_req  out  1  a word is offered to the memory.
- wr_addr  out  15  word address, BASE_ADDR + (mask_y*H_ACTIVE + mask_x)>>4, modulo 2^15.
- wr_data  out  16  bit i = mask of column (word base + i).
- wr_ack  in  1  memory accepts the offered word on this edge.
- frame_done  out  1  one-cycle pulse when the last word of the frame is acknowledged.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.

## Operation
- Accumulator: word index, 16-bit data, and an active flag. Data is preset to all 1s, so bits that never arrive read as 1, matching the mask reset value.
- valid with the same index as the active word: set bit mask_x[3:0] to mask.
- Word completes when valid arrives with mask_x[3:0]==15. The composed word (accumulator plus the new bit) is pushed this edge and the accumulator goes inactive.
- Index change while active (skipped pixels): push the partial word this edge, then start a new accumulator with the incoming pixel.
  - If that incoming pixel also has mask_x[3:0]==15, mark the new word pending.
  - A pending word is pushed on the next edge.
  - A valid in that next cycle is processed against an empty accumulator.
- The packer makes at most one push per edge.
- Pixel (0,0) with valid is the frame start. It clears overflow. If a word is active, it is flushed first under the index-change rule.
- FIFO entry is {addr, data}.
  - Push while full and no pop on the same edge: the word is dropped and overflow is set.
  - Push and pop on the same edge while full: the push is accepted.
- Write port:
  - wr_req = FIFO not empty. wr_addr and wr_data show the head entry.
  - wr_addr and wr_data hold stable while wr_req is high and wr_ack is low.
  - wr_ack with wr_req high pops the head.
  - wr_ack with wr_req low is ignored.
- frame_done pulses on the pop edge of the entry with address BASE_ADDR + H_ACTIVE*V_ACTIVE/16 - 1.
- Packer states: EMPTY, ACCUM, PENDING. Transitions follow the rules above.
- Reset mid-operation: the FIFO and accumulator are discarded. Nothing is written.

## Timing
- Reset values: wr_req 0, wr_addr 0, wr_data 16'hFFFF, frame_done 0, overflow 0. FIFO empty, packer EMPTY.
- Latency:
  - Completing pixel sampled at edge t, FIFO previously empty: wr_req high during cycle t+1.
  - If wr_ack is high at edge t+1, the entry is popped there.
- Throughput: one word per cycle when wr_ack is held high.
- Input has no back-pressure. valid may be high every cycle.

## Structure
- Shared package:
  - MASK_WORD_W = 16.
  - MASK_ADDR_W = 15.
  - Packed FIFO entry type {addr, data}.
  - Frame geometry constants, also used by the mask reader.
- Sub-module mask_word_fifo: synchronous FIFO with full/empty and same-edge push/pop. The packer and write port stay in mask_writer.

## Test plan
- Row 0, x=0..15 all mask=1 except x=5 mask=0, wr_ack tied 1 → single write: addr 0, data 16'hFFDF, wr_req high one cycle.
- x=16..19 then x=48 (y=0) → partial push addr 1, data 16'hFFF0 for mask=0 inputs. New word index 3 accumulates.
- x=31 alone then x=40 on the next cycle (y=0) → PENDING word addr 1 (bit15 set per mask) pushed on the edge after. x=40 starts word 2.
- wr_ack held 0, push 5 complete words → first 4 queued, 5th dropped, overflow=1. Release ack → exactly 4 writes. Next (0,0) pixel clears overflow.
- Full frame 640x480 streaming, wr_ack random 50% → 19200 writes at addrs 0..19199 in order. frame_done pulses once, on the ack of addr 19199.
- Reset asserted with 3 words queued and wr_req high → all outputs return to reset values immediately. No write occurs after release.
